// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: state encoding,
// default parameter values and a counter-width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        DMA_BUSY = 2'd2
    } arbState_t;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Bits needed to hold 0..maxVal; never narrower than one bit.
    function automatic int cntWidth(input int maxVal);
        if (maxVal > 0) begin
            return $clog2(maxVal + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, DMA and RAM signal bundle for the memory port arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module mem_port_arbiter_sat_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != W'(MAX))) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count  = count_r;
    assign at_max = (count_r == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM port between the multicycle CPU and a DMA requester.
// CPU has priority; a starvation counter lets a waiting DMA request win eventually.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input logic              CLK,
    input logic              Reset,
    mem_port_arbiter_if.slave bus
);

    localparam int LAT_W = cntWidth(MEM_LAT - 1);
    localparam int SW    = cntWidth(STARVE_MAX);

    arbState_t         state_r;
    arbState_t         nextState_s;
    logic [LAT_W-1:0]  latCnt_r;
    logic              memEn_r;
    logic              memWe_r;
    logic [ADDR_W-1:0] memAddr_r;
    logic [DATA_W-1:0] memWdata_r;

    logic              cpuReq_s;
    logic              cpuGrant_s;
    logic              dmaGrant_s;
    logic              latZero_s;
    logic              cpuDone_s;
    logic              dmaDone_s;
    logic [SW-1:0]     starveCnt_s;
    logic              starveAtMax_s;

    assign cpuReq_s  = bus.cpu_read | bus.cpu_write;
    assign latZero_s = (latCnt_r == LAT_W'(0));

    // Counts cycles a pending DMA request has been passed over.
    mem_port_arbiter_sat_counter #(
        .W   (SW),
        .MAX (STARVE_MAX)
    ) u_starve (
        .CLK    (CLK),
        .Reset  (Reset),
        .inc    (bus.dma_req && !dmaGrant_s && !starveAtMax_s),
        .clr    (dmaGrant_s || !bus.dma_req),
        .count  (starveCnt_s),
        .at_max (starveAtMax_s)
    );

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state and grant decision; grants happen only from IDLE.
    always_comb begin
        nextState_s = state_r;
        cpuGrant_s  = 1'b0;
        dmaGrant_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.dma_req && (!cpuReq_s || (starveCnt_s == SW'(STARVE_MAX)))) begin
                    dmaGrant_s  = 1'b1;
                    nextState_s = DMA_BUSY;
                end else if (cpuReq_s) begin
                    cpuGrant_s  = 1'b1;
                    nextState_s = CPU_BUSY;
                end else begin
                    nextState_s = IDLE;
                end
            end
            CPU_BUSY, DMA_BUSY: begin
                if (latZero_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = state_r;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // RAM command registers and latency counter; mem_en pulses in the first BUSY cycle only.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            memEn_r    <= 1'b0;
            memWe_r    <= 1'b0;
            memAddr_r  <= {ADDR_W{1'b0}};
            memWdata_r <= {DATA_W{1'b0}};
            latCnt_r   <= LAT_W'(0);
        end else begin
            memEn_r <= cpuGrant_s | dmaGrant_s;
            if (dmaGrant_s) begin
                memWe_r    <= bus.dma_we;
                memAddr_r  <= bus.dma_addr;
                memWdata_r <= bus.dma_wdata;
                latCnt_r   <= LAT_W'(MEM_LAT - 1);
            end else if (cpuGrant_s) begin
                memWe_r    <= bus.cpu_write;
                memAddr_r  <= bus.cpu_addr;
                memWdata_r <= bus.cpu_wdata;
                latCnt_r   <= LAT_W'(MEM_LAT - 1);
            end else begin
                memWe_r <= 1'b0;
                if ((state_r != IDLE) && !latZero_s) begin
                    latCnt_r <= latCnt_r - LAT_W'(1);
                end else begin
                    latCnt_r <= latCnt_r;
                end
            end
        end
    end

    // Completion decode and requester-side outputs, valid in the done cycle.
    always_comb begin
        cpuDone_s     = 1'b0;
        dmaDone_s     = 1'b0;
        bus.cpu_rdata = {DATA_W{1'b0}};
        bus.dma_rdata = {DATA_W{1'b0}};
        case (state_r)
            CPU_BUSY: cpuDone_s = latZero_s;
            DMA_BUSY: dmaDone_s = latZero_s;
            default:  cpuDone_s = 1'b0;
        endcase
        if (cpuDone_s) begin
            bus.cpu_rdata = bus.mem_rdata;
        end else begin
            bus.cpu_rdata = {DATA_W{1'b0}};
        end
        if (dmaDone_s) begin
            bus.dma_rdata = bus.mem_rdata;
        end else begin
            bus.dma_rdata = {DATA_W{1'b0}};
        end
    end

    assign bus.cpu_stall = cpuReq_s && !cpuDone_s;
    assign bus.dma_ack   = dmaDone_s;
    assign bus.mem_en    = memEn_r;
    assign bus.mem_we    = memWe_r;
    assign bus.mem_addr  = memAddr_r;
    assign bus.mem_wdata = memWdata_r;

endmodule
